// File: rtl/writeback_stage_pkg.sv
// Shared constants and types for the writeback stage.
//   XLEN / NUM_REGS / REG_AW : datapath width and register-file geometry
//   alu_op_t                 : ALU operation encoding
//   wb_state_t               : writeback FSM states
//   ex_wb_t                  : EX->WB pipeline register contents
package writeback_stage_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;

    typedef enum logic {
        WB_CLEAR,
        WB_RUN
    } wb_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu_result;
        logic              alu_result_ready;
        logic [REG_AW-1:0] reg_wr_addr;
        logic              reg_wr_en;
    } ex_wb_t;

endpackage

// File: rtl/writeback_stage_regfile_2r1w.sv
// regfile_2r1w: integer register storage, one synchronous write port and
// two asynchronous read ports. Entry 0 always reads as zero.
//   clk              : clock
//   we/waddr/wdata   : write port (posedge)
//   raddr_a/raddr_b  : read addresses
//   rdata_a/rdata_b  : combinational read data
module regfile_2r1w #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] mem [NUM_REGS];

    // Storage has no reset; the owning stage clears it explicitly.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: commits ALU results from EX_WB into the register file,
// serves two registered read ports with write-to-read bypass, and clears
// the register file after reset while holding upstream off with wb_busy.
//   clk, reset        : clock, synchronous active-high reset
//   ex_wb_reg         : EX->WB pipeline register
//   rs1_addr/rs2_addr : read addresses for ALU operands A/B
//   alu_reg_input_a/b : registered read data (1-cycle latency)
//   wb_busy           : high while the clear sequence runs
//   retired_count     : ALU results consumed in RUN (wraps)
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN           = writeback_stage_pkg::XLEN,
    parameter int NUM_REGS       = writeback_stage_pkg::NUM_REGS,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  ex_wb_t                      ex_wb_reg,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
    output logic [XLEN-1:0]             alu_reg_input_a,
    output logic [XLEN-1:0]             alu_reg_input_b,
    output logic                        wb_busy,
    output logic [31:0]                 retired_count
);

    localparam int            AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    wb_state_t     state, state_nxt;
    logic [AW-1:0] clear_idx, clear_idx_nxt;

    logic            clearing, running, commit;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [XLEN-1:0] rf_rdata_a, rf_rdata_b;
    logic [XLEN-1:0] rd_a_nxt, rd_b_nxt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? WB_CLEAR : WB_RUN;
            clear_idx <= '0;
        end else begin
            state     <= state_nxt;
            clear_idx <= clear_idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_idx_nxt = clear_idx;
        case (state)
            WB_CLEAR: begin
                clear_idx_nxt = clear_idx + AW'(1);
                if (clear_idx == LAST_IDX) state_nxt = WB_RUN;
            end
            default: ;
        endcase
    end

    assign clearing = (state == WB_CLEAR);
    assign running  = (state == WB_RUN);
    assign wb_busy  = clearing;

    // Writes to x0 never commit, so they can never be bypassed either.
    assign commit = running && ex_wb_reg.alu_result_ready && ex_wb_reg.reg_wr_en &&
                    (ex_wb_reg.reg_wr_addr != '0);

    // The clear sequence borrows the single write port.
    assign rf_we    = clearing || commit;
    assign rf_waddr = clearing ? clear_idx : ex_wb_reg.reg_wr_addr;
    assign rf_wdata = clearing ? '0 : ex_wb_reg.alu_result;

    regfile_2r1w #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk     (clk),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs1_addr),
        .raddr_b (rs2_addr),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    // ---------------- Read ports with bypass ----------------
    always_comb begin
        rd_a_nxt = rf_rdata_a;
        rd_b_nxt = rf_rdata_b;
        if (clearing || rs1_addr == '0)                  rd_a_nxt = '0;
        else if (commit && ex_wb_reg.reg_wr_addr == rs1_addr) rd_a_nxt = ex_wb_reg.alu_result;
        if (clearing || rs2_addr == '0)                  rd_b_nxt = '0;
        else if (commit && ex_wb_reg.reg_wr_addr == rs2_addr) rd_b_nxt = ex_wb_reg.alu_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_reg_input_a <= '0;
            alu_reg_input_b <= '0;
        end else begin
            alu_reg_input_a <= rd_a_nxt;
            alu_reg_input_b <= rd_b_nxt;
        end
    end

    // ---------------- Retired counter ----------------
    // Counts every result the stage consumes, including x0 targets and
    // results that carry no register write.
    always_ff @(posedge clk) begin
        if (reset)                                  retired_count <= '0;
        else if (running && ex_wb_reg.alu_result_ready) retired_count <= retired_count + 32'd1;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected values for
// the next edge into a queue; a negedge monitor pops and compares.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    ex_wb_t      ex_wb_reg;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] alu_reg_input_a, alu_reg_input_b, retired_count;
    logic        wb_busy;

    writeback_stage #(.XLEN(32), .NUM_REGS(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_wb_reg       (ex_wb_reg),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .alu_reg_input_a (alu_reg_input_a),
        .alu_reg_input_b (alu_reg_input_b),
        .wb_busy         (wb_busy),
        .retired_count   (retired_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int SEL_A = 0, SEL_B = 1, SEL_BUSY = 2, SEL_RET = 3;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Expectation for the outputs after the next posedge.
    task automatic expect_nx(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc + 1; e.sel = sel; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic drive(input logic rdy, input logic en, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        ex_wb_reg.alu_result_ready = rdy;
        ex_wb_reg.reg_wr_en        = en;
        ex_wb_reg.reg_wr_addr      = wa;
        ex_wb_reg.alu_result       = wd;
        rs1_addr = r1;
        rs2_addr = r2;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor
    exp_t        me;
    logic [31:0] act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            case (me.sel)
                SEL_A:    act = alu_reg_input_a;
                SEL_B:    act = alu_reg_input_b;
                SEL_BUSY: act = {31'd0, wb_busy};
                default:  act = retired_count;
            endcase
            checks++;
            if (me.cyc != cyc || act !== me.val) begin
                failures++;
                $display("FAIL %s cyc=%0d (due %0d) got=%h expected=%h",
                         me.name, cyc, me.cyc, act, me.val);
            end
        end
    end

    // Reset for one cycle, then run n clear cycles while presenting junk
    // writes that must be ignored.
    task automatic reset_and_clear(input int n);
        drive(1'b1, 1'b1, 5'd9, 32'h0BAD_0BAD, 5'd9, 5'd9);
        reset = 1'b1;
        expect_nx(SEL_BUSY, 32'd1, "rst_busy");
        expect_nx(SEL_A,    32'd0, "rst_a");
        expect_nx(SEL_B,    32'd0, "rst_b");
        expect_nx(SEL_RET,  32'd0, "rst_ret");
        step();
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            expect_nx(SEL_BUSY, (i < 31) ? 32'd1 : 32'd0, "clr_busy");
            expect_nx(SEL_RET,  32'd0, "clr_ret");
            expect_nx(SEL_A,    32'd0, "clr_a_forced0");
            step();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step();

        reset_and_clear(32);

        // All registers read back as zero after clear.
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(r), 5'(32 - r));
            expect_nx(SEL_A, 32'd0, "sweep_a");
            expect_nx(SEL_B, 32'd0, "sweep_b");
            if (r == 1) expect_nx(SEL_RET, 32'd0, "sweep_ret");
            step();
        end

        // Commit x5, then read it back.
        drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd0);
        expect_nx(SEL_A, 32'd0, "c5_a");
        expect_nx(SEL_RET, 32'd1, "c5_ret");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        expect_nx(SEL_A, 32'h1234_5678, "rd5_a");
        expect_nx(SEL_B, 32'd0, "rd5_b");
        expect_nx(SEL_RET, 32'd1, "rd5_ret");
        step();

        // Same-cycle bypass on both ports.
        drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        expect_nx(SEL_A, 32'hDEAD_BEEF, "byp7_a");
        expect_nx(SEL_B, 32'hDEAD_BEEF, "byp7_b");
        expect_nx(SEL_RET, 32'd2, "byp7_ret");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5);
        expect_nx(SEL_A, 32'hDEAD_BEEF, "rd7_a");
        expect_nx(SEL_B, 32'h1234_5678, "rd5b_b");
        step();

        // x0 write discarded, still counted.
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        expect_nx(SEL_A, 32'd0, "x0w_a");
        expect_nx(SEL_RET, 32'd3, "x0w_ret");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        expect_nx(SEL_A, 32'd0, "x0r_a");
        expect_nx(SEL_B, 32'd0, "x0r_b");
        expect_nx(SEL_RET, 32'd3, "x0r_ret");
        step();

        // Ready without enable: counted, no write, no bypass.
        drive(1'b1, 1'b0, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd0);
        expect_nx(SEL_A, 32'd0, "noen_a");
        expect_nx(SEL_RET, 32'd4, "noen_ret");
        step();
        // Enable without ready: not a commit, not counted.
        drive(1'b0, 1'b1, 5'd3, 32'h1111_1111, 5'd3, 5'd3);
        expect_nx(SEL_A, 32'd0, "nordy_a");
        expect_nx(SEL_RET, 32'd4, "nordy_ret");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        expect_nx(SEL_A, 32'd0, "rd3_a");
        step();

        // Highest register, bypass on port B only.
        drive(1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5, 5'd30, 5'd31);
        expect_nx(SEL_A, 32'd0, "c31_a");
        expect_nx(SEL_B, 32'hA5A5_A5A5, "c31_b");
        expect_nx(SEL_RET, 32'd5, "c31_ret");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd7);
        expect_nx(SEL_A, 32'hA5A5_A5A5, "rd31_a");
        expect_nx(SEL_B, 32'hDEAD_BEEF, "rd7b_b");
        step();

        // Reset during RUN, then again mid-clear at cycle 10.
        reset_and_clear(10);
        reset_and_clear(32);

        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
        expect_nx(SEL_A, 32'd0, "post_rd5");
        expect_nx(SEL_B, 32'd0, "post_rd7");
        expect_nx(SEL_RET, 32'd0, "post_ret");
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd9);
        expect_nx(SEL_A, 32'd0, "post_rd31");
        expect_nx(SEL_B, 32'd0, "post_rd9");
        expect_nx(SEL_BUSY, 32'd0, "post_busy");
        step();

        step();
        step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Consumer end of the EX_WB pipeline register. It commits ALU results into the 32-entry integer register file. It serves the two registered read ports that feed the ALU operand inputs, with same-cycle write-to-read bypass. On reset it runs a 32-cycle clear sequence and signals busy so upstream stages stall.

Parameters:
XLEN, 32, data width of registers and results
NUM_REGS, 32, register count; address width is clog2(NUM_REGS) = 5
CLEAR_ON_RESET, 1, 1 = run the CLEAR sequence after reset; 0 = enter RUN directly after reset with register contents undefined

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
ex_wb_reg  input  EX_WB struct  uses alu_result[31:0], alu_result_ready, reg_wr_addr[4:0], reg_wr_en
rs1_addr  input  5  read port A address
rs2_addr  input  5  read port B address
alu_reg_input_a  output  32  registered read data for rs1 (ALU operand A)
alu_reg_input_b  output  32  registered read data for rs2 (ALU operand B)
wb_busy  output  1  high while the clear sequence runs; upstream must hold
retired_count  output  32  count of ALU results consumed in RUN

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset, sampled on posedge clk.
- Reset values:
  - alu_reg_input_a = 0, alu_reg_input_b = 0, retired_count = 0, clear_idx = 0.
  - state = WB_CLEAR and wb_busy = 1 when CLEAR_ON_RESET = 1.
  - state = WB_RUN and wb_busy = 0 when CLEAR_ON_RESET = 0.
- Reset asserted mid-CLEAR or mid-RUN: the same values are taken on the next edge, and the clear sequence restarts from index 0.
- WB_CLEAR:
  - Each cycle: regs[clear_idx] <= 0, clear_idx <= clear_idx + 1.
  - When clear_idx == 31: transition to WB_RUN on that edge, and wb_busy drops in the same cycle.
  - The sequence is exactly 32 cycles after reset deasserts.
  - ex_wb_reg is ignored: no commit, retired_count does not increment.
  - Both read outputs are forced to 0.
- WB_RUN commit condition: commit = alu_result_ready && reg_wr_en && (reg_wr_addr != 0).
  - On commit: regs[reg_wr_addr] <= alu_result at posedge.
  - Writes to x0 are discarded.
- retired_count increments by 1 on every RUN cycle with alu_result_ready = 1. This includes x0 targets and reg_wr_en = 0. It wraps modulo 2^32.
- Read ports, 1-cycle latency, evaluated in this priority order:
  - alu_reg_input_a <= 0 if rs1_addr == 0;
  - otherwise alu_result if commit && reg_wr_addr == rs1_addr (bypass);
  - otherwise regs[rs1_addr].
  - Port B is identical, using rs2_addr.
- Both ports may read the same address, including the one being written; both get the bypassed value.
- The x0 read is always 0, whatever was written to it.
- One write per cycle, no write conflicts. Registers hold their value when no commit occurs.

Decomposition:
- wb_state_t enum {WB_CLEAR, WB_RUN} goes in the shared enums header alongside the ALU op enums.
- EX_WB struct stays in the pipeline stage registers package and is not redefined here.
- XLEN and the register-count constants go in the shared package.
- One sub-module, regfile_2r1w: storage array with one write port and two asynchronous read ports, with x0 forced to 0.
- writeback_stage owns the FSM, clear counter, bypass muxes, output registers and retired counter.

Test Plan:
- Reset for 1 cycle, CLEAR_ON_RESET = 1 → wb_busy = 1 for exactly 32 cycles, then 0. Reading x1..x31 in RUN returns 0.
- RUN: commit addr 5 = 0x12345678. Next cycle read rs1 = 5 → alu_reg_input_a = 0x12345678 one edge later. retired_count = 1.
- Same-cycle bypass: commit addr 7 = 0xDEADBEEF while rs1 = 7 and rs2 = 7 → both outputs 0xDEADBEEF after that edge.
- Write addr 0 = 0xFFFFFFFF, then read rs1 = 0 → output 0. retired_count still increments.
- alu_result_ready = 1 with reg_wr_en = 0 to addr 3 → x3 unchanged, retired_count increments.
- Reset asserted at clear cycle 10 and during RUN after writes → clear restarts, wb_busy high for a full 32 cycles, retired_count = 0, prior register values read back as 0.
